// File: rtl/div_arbiter.sv
// Round-robin front end that shares one iterative divider among NREQ requesters.
// Divide-by-zero is answered locally; a watchdog aborts a divider that never answers.
module div_arbiter #(
    parameter int  N       = 16,
    parameter int  NREQ    = 4,
    parameter int  TIMEOUT = 64,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   in_valid,
    output logic [NREQ-1:0]   in_ready,
    input  logic [NREQ*N-1:0] in_dividend,
    input  logic [NREQ*N-1:0] in_divisor,
    output logic              out_valid,
    output logic [IDW-1:0]    out_id,
    output logic [N-1:0]      out_q,
    output logic [N-1:0]      out_r,
    output logic [1:0]        out_err,
    output logic              div_req,
    output logic [N-1:0]      div_dividend,
    output logic [N-1:0]      div_divisor,
    output logic              div_abort,
    input  logic [N-1:0]      div_q,
    input  logic [N-1:0]      div_r,
    input  logic              div_ready
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            out_valid_q, out_valid_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic [N-1:0]    out_q_q, out_q_d;
    logic [N-1:0]    out_r_q, out_r_d;
    logic [1:0]      out_err_q, out_err_d;
    logic            div_req_q, div_req_d;
    logic            div_abort_q, div_abort_d;
    logic [N-1:0]    div_dividend_q, div_dividend_d;
    logic [N-1:0]    div_divisor_q, div_divisor_d;

    logic            hi_found_s, lo_found_s, found_s;
    logic [IDW-1:0]  hi_idx_s, lo_idx_s, winner_s;
    logic [N-1:0]    sel_dividend_s, sel_divisor_s;
    logic            sel_zero_s;
    logic            timeout_s;
    logic [NREQ-1:0] in_ready_s;

    // Round-robin pick: lowest valid index above the last grant, else lowest valid at or below it.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {IDW{1'b0}};
        lo_idx_s   = {IDW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            hi_idx_s   = (in_valid[i] && (i > int'(last_q)))  ? IDW'(i) : hi_idx_s;
            lo_idx_s   = (in_valid[i] && (i <= int'(last_q))) ? IDW'(i) : lo_idx_s;
            hi_found_s = hi_found_s | (in_valid[i] && (i > int'(last_q)));
            lo_found_s = lo_found_s | (in_valid[i] && (i <= int'(last_q)));
        end
        found_s  = hi_found_s | lo_found_s;
        winner_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_dividend_s = {N{1'b0}};
        sel_divisor_s  = {N{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_dividend_s = (winner_s == IDW'(i)) ? in_dividend[i*N +: N] : sel_dividend_s;
            sel_divisor_s  = (winner_s == IDW'(i)) ? in_divisor[i*N +: N]  : sel_divisor_s;
        end
        sel_zero_s = (sel_divisor_s == {N{1'b0}});
        timeout_s  = (timer_q == TW'(TIMEOUT - 1));
    end

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            last_q         <= IDW'(NREQ - 1);
            id_q           <= {IDW{1'b0}};
            timer_q        <= {TW{1'b0}};
            out_valid_q    <= 1'b0;
            out_id_q       <= {IDW{1'b0}};
            out_q_q        <= {N{1'b0}};
            out_r_q        <= {N{1'b0}};
            out_err_q      <= 2'b00;
            div_req_q      <= 1'b0;
            div_abort_q    <= 1'b0;
            div_dividend_q <= {N{1'b0}};
            div_divisor_q  <= {N{1'b0}};
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            id_q           <= id_d;
            timer_q        <= timer_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_q_q        <= out_q_d;
            out_r_q        <= out_r_d;
            out_err_q      <= out_err_d;
            div_req_q      <= div_req_d;
            div_abort_q    <= div_abort_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d = sel_zero_s ? S_RESP : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (div_ready || timeout_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: result and pulse registers load on the edge that enters RESP or ISSUE.
    always_comb begin
        last_d         = last_q;
        id_d           = id_q;
        timer_d        = timer_q;
        out_valid_d    = 1'b0;
        out_id_d       = out_id_q;
        out_q_d        = out_q_q;
        out_r_d        = out_r_q;
        out_err_d      = out_err_q;
        div_req_d      = 1'b0;
        div_abort_d    = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    last_d         = winner_s;
                    id_d           = winner_s;
                    div_dividend_d = sel_dividend_s;
                    div_divisor_d  = sel_divisor_s;
                    if (sel_zero_s) begin
                        out_valid_d = 1'b1;
                        out_id_d    = winner_s;
                        out_q_d     = {N{1'b1}};
                        out_r_d     = sel_dividend_s;
                        out_err_d   = 2'b01;
                    end else begin
                        div_req_d   = 1'b1;
                    end
                end else begin
                    last_d = last_q;
                end
            end
            S_ISSUE: timer_d = {TW{1'b0}};
            S_WAIT: begin
                timer_d = timer_q + TW'(1'b1);
                if (div_ready) begin
                    out_valid_d = 1'b1;
                    out_id_d    = id_q;
                    out_q_d     = div_q;
                    out_r_d     = div_r;
                    out_err_d   = 2'b00;
                end else if (timeout_s) begin
                    out_valid_d = 1'b1;
                    out_id_d    = id_q;
                    out_q_d     = {N{1'b0}};
                    out_r_d     = {N{1'b0}};
                    out_err_d   = 2'b10;
                    div_abort_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            S_RESP:  out_valid_d = 1'b0;
            default: out_valid_d = 1'b0;
        endcase
    end

    // Accept strobe: one-hot winner, only in IDLE and never while reset is held.
    always_comb begin
        in_ready_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            in_ready_s[i] = rstn && (state_q == S_IDLE) && found_s && (winner_s == IDW'(i));
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_q        = out_q_q;
    assign out_r        = out_r_q;
    assign out_err      = out_err_q;
    assign div_req      = div_req_q;
    assign div_abort    = div_abort_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a fixed-latency divider model that can be silenced.
`timescale 1ns/1ps
module tb_div_arbiter;
    localparam int N = 16, NREQ = 4, TIMEOUT = 64, IDW = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   in_valid, in_ready;
    logic [NREQ*N-1:0] in_dividend, in_divisor;
    logic              out_valid;
    logic [IDW-1:0]    out_id;
    logic [N-1:0]      out_q, out_r;
    logic [1:0]        out_err;
    logic              div_req, div_abort;
    logic [N-1:0]      div_dividend, div_divisor, div_q, div_r;
    logic              model_ready, tb_ready, model_en;
    int                model_lat, model_cnt;
    int                vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    div_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_id(out_id), .out_q(out_q), .out_r(out_r), .out_err(out_err),
        .div_req(div_req), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_abort(div_abort), .div_q(div_q), .div_r(div_r), .div_ready(model_ready | tb_ready)
    );

    // Divider model: ready pulses model_lat cycles after the cycle div_req is seen.
    always @(negedge clk) begin
        model_ready = 1'b0;
        if (!model_en || !rstn) begin
            model_cnt = 0;
        end else if (div_req) begin
            model_cnt = model_lat;
            div_q = div_dividend / div_divisor;
            div_r = div_dividend % div_divisor;
        end else if (model_cnt == 1) begin
            model_ready = 1'b1;
            model_cnt = 0;
        end else if (model_cnt > 1) begin
            model_cnt = model_cnt - 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid[id] = 1'b1;
        in_dividend[id*N +: N] = a;
        in_divisor[id*N +: N] = b;
    endtask

    task automatic test_reset;
        rstn = 1'b0; tb_ready = 1'b0; model_en = 1'b1; model_lat = 3;
        in_dividend = '0; in_divisor = '0; in_valid = 4'b1111;
        tick; tick;
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if ({out_id, out_q, out_r, out_err} !== 36'd0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", {out_id, out_q, out_r, out_err}); end
        vectors++; if ({div_req, div_abort, div_dividend, div_divisor} !== 34'd0) begin miscompares++; $display("FAIL reset_div: got %h expected 0", {div_req, div_abort, div_dividend, div_divisor}); end
        in_valid = 4'b0000; rstn = 1'b1;
        tick;
    endtask

    task automatic test_single;
        int seen;
        set_req(0, 16'd65000, 16'd6700); #1;
        vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b expected 0001", in_ready); end
        tick; in_valid = 4'b0000;
        vectors++; if ({div_req, div_dividend, div_divisor} !== {1'b1, 16'd65000, 16'd6700}) begin miscompares++; $display("FAIL single_issue: got %b %0d %0d expected 1 65000 6700", div_req, div_dividend, div_divisor); end
        tick;
        vectors++; if (div_req !== 1'b0) begin miscompares++; $display("FAIL single_req_pulse: got %b expected 0", div_req); end
        seen = 0;
        for (int t = 3; t <= 40; t++) begin tick; if (out_valid) begin seen = t; break; end end
        vectors++; if (seen !== 5) begin miscompares++; $display("FAIL single_latency: got cycle %0d expected 5", seen); end
        vectors++; if ({out_id, out_q, out_r, out_err} !== {2'd0, 16'd9, 16'd4700, 2'b00}) begin miscompares++; $display("FAIL single_result: got id %0d q %0d r %0d err %b expected 0 9 4700 00", out_id, out_q, out_r, out_err); end
        tick;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_pulse: got %b expected 0", out_valid); end
    endtask

    task automatic test_div_zero;
        set_req(2, 16'd1234, 16'd0); #1;
        vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL dz_grant: got %b expected 0100", in_ready); end
        tick; in_valid = 4'b0000;
        vectors++; if ({out_valid, div_req} !== 2'b10) begin miscompares++; $display("FAIL dz_valid: got valid %b req %b expected 1 0", out_valid, div_req); end
        vectors++; if ({out_id, out_q, out_r, out_err} !== {2'd2, 16'hFFFF, 16'd1234, 2'b01}) begin miscompares++; $display("FAIL dz_result: got id %0d q %h r %0d err %b expected 2 ffff 1234 01", out_id, out_q, out_r, out_err); end
        tick;
        vectors++; if ({out_valid, div_req} !== 2'b00) begin miscompares++; $display("FAIL dz_after: got valid %b req %b expected 0 0", out_valid, div_req); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_oh;
        int exp_id;
        int seen;
        rstn = 1'b0; tick; rstn = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 16'd100, 16'd7);
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_id = k % NREQ;
            exp_oh = 4'b0001 << exp_id;
            for (int t = 0; t < 20; t++) begin if (in_ready !== 4'b0000) break; tick; end
            vectors++; if (in_ready !== exp_oh) begin miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", k, in_ready, exp_oh); end
            seen = 0;
            for (int t = 1; t <= 40; t++) begin tick; if (out_valid) begin seen = t; break; end end
            vectors++; if (seen !== 5) begin miscompares++; $display("FAIL rr_latency%0d: got %0d expected 5", k, seen); end
            vectors++; if ({out_id, out_q, out_r, out_err} !== {2'(exp_id), 16'd14, 16'd2, 2'b00}) begin miscompares++; $display("FAIL rr_result%0d: got id %0d q %0d r %0d err %b expected %0d 14 2 00", k, out_id, out_q, out_r, out_err, exp_id); end
        end
        in_valid = 4'b0000;
        tick;
    endtask

    task automatic test_timeout;
        int seen;
        model_en = 1'b0;
        set_req(1, 16'd500, 16'd3); #1;
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL to_grant: got %b expected 0010", in_ready); end
        tick; in_valid = 4'b0000;
        tick;
        seen = 0;
        for (int t = 3; t <= 100; t++) begin tick; if (div_abort) begin seen = t; break; end end
        vectors++; if (seen !== 66) begin miscompares++; $display("FAIL to_abort_cycle: got %0d expected 66", seen); end
        vectors++; if ({out_valid, out_id, out_q, out_r, out_err} !== {1'b1, 2'd1, 16'd0, 16'd0, 2'b10}) begin miscompares++; $display("FAIL to_result: got v %b id %0d q %0d r %0d err %b expected 1 1 0 0 10", out_valid, out_id, out_q, out_r, out_err); end
        tick;
        vectors++; if ({div_abort, out_valid} !== 2'b00) begin miscompares++; $display("FAIL to_pulse: got abort %b valid %b expected 0 0", div_abort, out_valid); end
        model_en = 1'b1;
    endtask

    task automatic test_idle_ready;
        tb_ready = 1'b1; tick; tb_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            vectors++; if ({out_valid, in_ready} !== 5'b0) begin miscompares++; $display("FAIL idle_ready%0d: got valid %b in_ready %b expected 0 0000", t, out_valid, in_ready); end
            tick;
        end
        set_req(1, 16'd77, 16'd0); #1;
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL idle_accept: got %b expected 0010", in_ready); end
        tick; in_valid = 4'b0000;
        vectors++; if ({out_valid, out_r, out_err} !== {1'b1, 16'd77, 2'b01}) begin miscompares++; $display("FAIL idle_dz: got v %b r %0d err %b expected 1 77 01", out_valid, out_r, out_err); end
        tick;
    endtask

    task automatic test_reset_mid;
        int seen;
        model_lat = 20;
        set_req(0, 16'd1000, 16'd10); #1;
        vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL rm_grant: got %b expected 0001", in_ready); end
        tick; in_valid = 4'b0000;
        tick; tick;
        rstn = 1'b0;
        set_req(3, 16'd4321, 16'd100);
        tick;
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL rm_in_ready: got %b expected 0000", in_ready); end
        vectors++; if ({out_valid, out_id, out_err, div_req, div_abort} !== 7'd0) begin miscompares++; $display("FAIL rm_outputs: got v %b id %0d err %b req %b abort %b expected zeros", out_valid, out_id, out_err, div_req, div_abort); end
        vectors++; if ({div_dividend, div_divisor, out_q, out_r} !== 64'd0) begin miscompares++; $display("FAIL rm_data: got %h expected 0", {div_dividend, div_divisor, out_q, out_r}); end
        rstn = 1'b1; model_lat = 3; #1;
        vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL rm_grant3: got %b expected 1000", in_ready); end
        tick; in_valid = 4'b0000;
        seen = 0;
        for (int t = 2; t <= 40; t++) begin tick; if (out_valid) begin seen = t; break; end end
        vectors++; if (seen !== 5) begin miscompares++; $display("FAIL rm_latency: got %0d expected 5", seen); end
        vectors++; if ({out_id, out_q, out_r, out_err} !== {2'd3, 16'd43, 16'd21, 2'b00}) begin miscompares++; $display("FAIL rm_result: got id %0d q %0d r %0d err %b expected 3 43 21 00", out_id, out_q, out_r, out_err); end
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_div_zero;
        test_back_to_back;
        test_timeout;
        test_idle_ready;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
